mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter that sits on the single-cycle RISC-V core's data bus, in parallel with the data memory. It accepts byte stores from the core into a small FIFO and serialises them on `tx` as 8N1 frames. It also exposes a status word for software polling. The top level muxes `ReadData` and gates the data memory write using `Sel`.

## Interface

**Parameters**

- `BASE_ADDR`, default 32'h0000_0400: byte address of the 8-byte register window. Must be 8-byte aligned.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be ≥ 2.
- `FIFO_DEPTH`, default 4: TX FIFO entries. Must be a power of two, ≥ 2.

**Ports** (one clock; reset is synchronous and active-high)

- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `MemWrite` in 1: core store strobe.
- `DataAdr` in 32: core data address (ALUResult).
- `WriteData` in 32: core store data.
- `ReadData` out 32: register read data, combinational.
- `Sel` out 1: address falls in the window, combinational.
- `tx` out 1: serial output, idle high.
- `busy` out 1: shifter is not IDLE.

## Operation

**Address decode**

- `Sel` = (`DataAdr[31:3]` == `BASE_ADDR[31:3]`).
- Offset 0x0 is TXDATA. Offset 0x4 is STATUS. Selection uses `DataAdr[2]`. `DataAdr[1:0]` is ignored.

**Writes** (at the rising edge, when `MemWrite & Sel`)

- TXDATA:
  - If the FIFO is not full (evaluated before the edge), push `WriteData[7:0]`.
  - If the FIFO is full, drop the data and set sticky `ovf`. This holds even if a pop happens on the same edge.
- STATUS: if `WriteData[3]`=1, clear `ovf`. All other bits are ignored.

**Reads** (combinational)

- STATUS returns:
  - bit0 `full`
  - bit1 `empty`
  - bit2 `busy`
  - bit3 `ovf`
  - bits[7:4] FIFO count, saturating at 15
  - all other bits 0
- TXDATA reads 0.
- When `Sel`=0, `ReadData` is 0.

**FIFO**

- Circular buffer with read and write pointers and a count of width $clog2(FIFO_DEPTH)+1.
- A push and a pop on the same edge leave the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

**Shifter FSM**

- States are IDLE, START, DATA, STOP. A bit counter counts 0..CLKS_PER_BIT-1 and a bit index counts 0..7.
- IDLE:
  - `tx`=1.
  - If the FIFO is non-empty, pop the head into the shift register and go to START. The counter resets to 0.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
- DATA:
  - `tx` = shift[index], LSB first, CLKS_PER_BIT cycles per bit.
  - After index 7 completes, go to STOP.
- STOP:
  - `tx`=1 for CLKS_PER_BIT cycles.
  - On the final cycle, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- `busy`=1 in every state except IDLE.

## Timing

**Reset values** (on a reset edge)

- FSM goes to IDLE, FIFO empties, pointers and count clear, `ovf`=0, counters clear.
- `tx`=1, `busy`=0.
- `ReadData`/`Sel` are combinational and follow the inputs.

**Reset mid-frame**

- `tx` is high after the reset edge.
- Queued bytes are discarded.
- A store on the reset edge is ignored.

**Latency**

- Store into an empty FIFO while IDLE at edge E:
  - count=1 after E.
  - Pop at E+1; `tx` falls after E+1 and `busy`=1 after E+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles. `tx` changes only at bit boundaries.
- Back-to-back frames have the stop bit followed immediately by the next start bit.

**Status**

- STATUS reflects state after the most recent edge.
- A store and a status read are never in the same cycle. Single-cycle core, one bus access per cycle.

**Registering**

- `tx` and `busy` are registered outputs: no combinational path from bus inputs to `tx`.

## Test plan

1. **Single byte.** CLKS_PER_BIT=4. Store 0x55 to 0x400 at edge E.
   - `tx` after E+1: 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles.
   - `busy` falls after E+41.
2. **Back-to-back.** Stores of 0xA3 and 0x0F on consecutive edges. Two frames with no idle cycle between the stop bit and the second start bit; total 80 busy cycles.
3. **Overflow.** Depth 4. Six stores on consecutive edges E0..E5.
   - Five bytes are accepted; the E5 store is dropped.
   - STATUS reads 0x4D after E5 (count 4, ovf, busy, full).
   - Writing 0x8 to 0x404 then clears `ovf`.
4. **Decode.** Stores to 0x3FC and 0x408 leave the FIFO unchanged with `Sel`=0. A read of 0x404 when idle and empty returns 0x2. A read of 0x400 returns 0.
5. **Reset mid-frame.** Assert `reset` during DATA with 2 bytes queued.
   - Next cycle: `tx`=1, `busy`=0, STATUS=0x2.
   - A later store transmits normally.
6. **Wrap-around.** Push and transmit 9 bytes in sequence through a depth-4 FIFO. Output byte order matches input order across pointer wrap.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window on the core data bus,
// byte FIFO feeding a START/DATA/STOP shifter with registered tx/busy outputs.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Sel,
   output logic        tx,
   output logic        busy
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BitW = $clog2(CLKS_PER_BIT);
   localparam logic [BitW-1:0] BitLast = BitW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            state_q, state_d;
   logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;

   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q;
   logic              ovf_q;

   logic              wr_en, push_req, push, pop, full, empty, ovf_clr, bit_last;
   logic [3:0]        count_sat;
   logic              unused;

   assign unused = ^{DataAdr[1:0], WriteData[31:8], WriteData[7:4], WriteData[2:0]};

   // Bus decode and status
   always_comb begin
      Sel       = (DataAdr[31:3] == BASE_ADDR[31:3]);
      wr_en     = MemWrite & Sel;
      push_req  = wr_en & ~DataAdr[2];
      ovf_clr   = wr_en & DataAdr[2] & WriteData[3];
      full      = (count_q == Depth);
      empty     = (count_q == '0);
      push      = push_req & ~full;
      count_sat = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);
      ReadData  = '0;
      if (Sel && DataAdr[2]) begin
         ReadData = {24'b0, count_sat, ovf_q, busy_q, empty, full};
      end
   end

   // Shifter next state; tx/busy are derived from the next state so they come out registered
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      pop       = 1'b0;
      bit_last  = (bit_cnt_q == BitLast);
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop       = 1'b1;
               shift_d   = mem_q[rd_ptr_q];
               bit_cnt_d = '0;
               state_d   = StStart;
            end
         end
         StStart: begin
            if (bit_last) begin
               bit_cnt_d = '0;
               idx_d     = 3'd0;
               state_d   = StData;
            end else begin
               bit_cnt_d = bit_cnt_q + BitW'(1);
            end
         end
         StData: begin
            if (bit_last) begin
               bit_cnt_d = '0;
               if (idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + BitW'(1);
            end
         end
         StStop: begin
            if (bit_last) begin
               bit_cnt_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + BitW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      if (state_d == StStart) begin
         tx_d = 1'b0;
      end else if (state_d == StData) begin
         tx_d = shift_d[idx_d];
      end else begin
         tx_d = 1'b1;
      end
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (push && !pop) begin
            count_q <= count_q + CntW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CntW'(1);
         end
         // Fullness is judged before the edge, so a same-edge pop does not rescue the store
         if (push_req && full) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr) begin
            ovf_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem_q[wr_ptr_q] <= WriteData[7:0];
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: decode vector table plus frame, overflow, reset and
// wrap-around sequences checked against hand-computed values and a serial receiver model.
module tb_mmio_uart_tx;

   localparam int Cpb = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Sel;
   logic        tx;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] rx_q [$];
   logic [7:0] exp_q [$];

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_sel;
   } vec_t;

   vec_t vecs [10];

   mmio_uart_tx #(
      .BASE_ADDR    (32'h0000_0400),
      .CLKS_PER_BIT (Cpb),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .DataAdr   (DataAdr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .Sel       (Sel),
      .tx        (tx),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Receiver model: on a start bit, sample each data bit mid-cell
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            repeat (Cpb / 2) @(negedge clk);
            for (int j = 0; j < 8; j++) begin
               repeat (Cpb) @(negedge clk);
               b[j] = tx;
            end
            repeat (Cpb) @(negedge clk);
            rx_q.push_back(b);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      MemWrite  = 1'b1;
      DataAdr   = a;
      WriteData = d;
      @(posedge clk);
      #1;
      MemWrite  = 1'b0;
      DataAdr   = 32'h404;
   endtask

   task automatic read_status(output logic [31:0] s);
      MemWrite = 1'b0;
      DataAdr  = 32'h404;
      #1;
      s = ReadData;
   endtask

   // Called at the first start-bit cycle; walks the full 10-bit frame
   task automatic frame_check(input logic [7:0] b, input string nm);
      int terr = 0;
      int berr = 0;
      logic e;
      for (int i = 0; i < 10 * Cpb; i++) begin
         if (i < Cpb) e = 1'b0;
         else if (i >= 9 * Cpb) e = 1'b1;
         else e = b[(i / Cpb) - 1];
         if (tx !== e) terr++;
         if (busy !== 1'b1) berr++;
         @(posedge clk);
         #1;
      end
      chk({nm, " tx bad cycles"}, terr, 0);
      chk({nm, " busy bad cycles"}, berr, 0);
   endtask

   task automatic wait_idle(input string nm, input int max);
      logic [31:0] s;
      int k = 0;
      read_status(s);
      while (!(busy === 1'b0 && s[1] === 1'b1) && k < max) begin
         @(posedge clk);
         #1;
         read_status(s);
         k++;
      end
      chk({nm, " idle within budget"}, 32'(k < max), 1);
   endtask

   task automatic check_rx(input string nm);
      chk({nm, " rx count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         chk($sformatf("%s rx byte %0d", nm, i), rx_q[i], exp_q[i]);
      end
   endtask

   initial begin
      logic [31:0] s;
      logic [7:0] wb [9];

      vecs[0] = '{1'b1, 32'h0000_03FC, 32'h77,        32'h0, 1'b0};
      vecs[1] = '{1'b1, 32'h0000_0408, 32'h77,        32'h0, 1'b0};
      vecs[2] = '{1'b0, 32'h0000_0404, 32'h0,         32'h2, 1'b1};
      vecs[3] = '{1'b0, 32'h0000_0400, 32'h0,         32'h0, 1'b1};
      vecs[4] = '{1'b0, 32'h0000_0406, 32'h0,         32'h2, 1'b1};
      vecs[5] = '{1'b0, 32'h0000_0402, 32'h0,         32'h0, 1'b1};
      vecs[6] = '{1'b1, 32'h0000_0404, 32'hFFFF_FFF7, 32'h2, 1'b1};
      vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0, 1'b0};
      vecs[8] = '{1'b0, 32'hFFFF_FC04, 32'h0,         32'h0, 1'b0};
      vecs[9] = '{1'b0, 32'h0000_0404, 32'h0,         32'h2, 1'b1};
      wb = '{8'h01, 8'h80, 8'hFE, 8'h5A, 8'hC3, 8'h7E, 8'h00, 8'hFF, 8'h96};

      reset     = 1'b1;
      MemWrite  = 1'b0;
      DataAdr   = 32'h404;
      WriteData = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset tx", tx, 1);
      chk("reset busy", busy, 0);
      read_status(s);
      chk("reset status", s, 32'h2);

      // Single byte with exact latency
      bus_write(32'h400, 32'h55);
      chk("single busy after store", busy, 0);
      chk("single tx after store", tx, 1);
      read_status(s);
      chk("single status after store", s, 32'h10);
      @(posedge clk);
      #1;
      frame_check(8'h55, "single");
      chk("single busy fall", busy, 0);
      chk("single tx idle", tx, 1);

      // Back-to-back frames, no idle gap
      bus_write(32'h400, 32'hA3);
      bus_write(32'h400, 32'h0F);
      frame_check(8'hA3, "b2b first");
      frame_check(8'h0F, "b2b second");
      chk("b2b busy fall", busy, 0);

      // Overflow
      rx_q.delete();
      for (int i = 0; i < 6; i++) bus_write(32'h400, 32'h10 + i);
      read_status(s);
      chk("ovf status", s, 32'h4D);
      bus_write(32'h404, 32'h8);
      read_status(s);
      chk("ovf cleared status", s, 32'h45);
      wait_idle("ovf drain", 400);
      exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      check_rx("ovf");
      read_status(s);
      chk("ovf final status", s, 32'h2);

      // Decode table
      for (int i = 0; i < 10; i++) begin
         MemWrite  = vecs[i].we;
         DataAdr   = vecs[i].adr;
         WriteData = vecs[i].wd;
         #1;
         chk($sformatf("decode %0d ReadData", i), ReadData, vecs[i].exp_rd);
         chk($sformatf("decode %0d Sel", i), 32'(Sel), 32'(vecs[i].exp_sel));
         @(posedge clk);
         #1;
         MemWrite = 1'b0;
      end
      chk("decode busy", busy, 0);

      // Reset mid-frame with two bytes queued and a store on the reset edge
      bus_write(32'h400, 32'h81);
      bus_write(32'h400, 32'h42);
      bus_write(32'h400, 32'h24);
      repeat (8) begin
         @(posedge clk);
         #1;
      end
      reset     = 1'b1;
      MemWrite  = 1'b1;
      DataAdr   = 32'h400;
      WriteData = 32'h99;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      MemWrite = 1'b0;
      chk("midreset tx", tx, 1);
      chk("midreset busy", busy, 0);
      read_status(s);
      chk("midreset status", s, 32'h2);
      repeat (50) begin
         @(posedge clk);
         #1;
      end
      chk("midreset stays idle", busy, 0);
      rx_q.delete();
      bus_write(32'h400, 32'h3C);
      wait_idle("midreset retx", 200);
      exp_q = '{8'h3C};
      check_rx("midreset");

      // Wrap-around through the depth-4 FIFO with full-flag flow control
      rx_q.delete();
      exp_q.delete();
      for (int i = 0; i < 9; i++) begin
         int k = 0;
         read_status(s);
         while (s[0] === 1'b1 && k < 200) begin
            @(posedge clk);
            #1;
            read_status(s);
            k++;
         end
         bus_write(32'h400, {24'b0, wb[i]});
         exp_q.push_back(wb[i]);
      end
      wait_idle("wrap", 1000);
      check_rx("wrap");
      read_status(s);
      chk("wrap final status", s, 32'h2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
